// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type funct codes used by the ALU control decoder
// and by the multiply/divide unit.
package mips_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

endpackage

// File: rtl/mdu_datapath.sv
// Combinational single-iteration step for the multiply/divide unit plus the
// final sign correction applied to the magnitude result.
module mdu_datapath #(
   parameter int WIDTH = 32
) (
   input  logic               isDiv_i,
   input  logic               negHi_i,
   input  logic               negLo_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opMag_i,
   output logic [2*WIDTH-1:0] accStep_o,
   output logic [WIDTH-1:0]   hiFix_o,
   output logic [WIDTH-1:0]   loFix_o
);

   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   diff;
   logic               ge;
   logic [2*WIDTH-1:0] prodFix;

   // Multiply: acc = {partial, multiplier}, add on LSB then shift right.
   // Divide:   acc = {remainder, dividend/quotient}, shift left and restore.
   always_comb begin
      mulSum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opMag_i} : '0);
      trial  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      ge     = (trial >= {1'b0, opMag_i});
      diff   = trial[WIDTH-1:0] - opMag_i;
      if (isDiv_i) begin
         accStep_o = {(ge ? diff : trial[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
      end else begin
         accStep_o = {mulSum, acc_i[WIDTH-1:1]};
      end
   end

   // For multiply the whole double-width product is negated as one value.
   always_comb begin
      prodFix = negLo_i ? -acc_i : acc_i;
      if (isDiv_i) begin
         hiFix_o = negHi_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
         loFix_o = negLo_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
      end else begin
         hiFix_o = prodFix[2*WIDTH-1:WIDTH];
         loFix_o = prodFix[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle, a sign-fix
// cycle, and a busy/done handshake for the hazard unit.
module mul_div_unit
   import mips_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

   mdu_state_t         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opMag_q;
   logic               isDiv_q, negHi_q, negLo_q, dbzPend_q;
   logic               busy_q, done_q, dbz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               signedOp, aNeg, bNeg, bZero;
   logic [WIDTH-1:0]   aMag, bMag;
   logic [2*WIDTH-1:0] accStep_d;
   logic [WIDTH-1:0]   hiFix_d, loFix_d;

   always_comb begin
      signedOp = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
      aNeg     = signedOp & op_a[WIDTH-1];
      bNeg     = signedOp & op_b[WIDTH-1];
      aMag     = aNeg ? -op_a : op_a;
      bMag     = bNeg ? -op_b : op_b;
      bZero    = (op_b == '0);
   end

   mdu_datapath #(.WIDTH(WIDTH)) uDatapath (
      .isDiv_i   (isDiv_q),
      .negHi_i   (negHi_q),
      .negLo_i   (negLo_q),
      .acc_i     (acc_q),
      .opMag_i   (opMag_q),
      .accStep_o (accStep_d),
      .hiFix_o   (hiFix_d),
      .loFix_o   (loFix_d)
   );

   // Quotient keeps its all-ones magnitude on divide by zero, so its sign
   // flag is suppressed there; the remainder still follows the dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opMag_q   <= '0;
         isDiv_q   <= 1'b0;
         negHi_q   <= 1'b0;
         negLo_q   <= 1'b0;
         dbzPend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  case (funct)
                     FUNCT_MULT, FUNCT_MULTU: begin
                        acc_q     <= {{WIDTH{1'b0}}, bMag};
                        opMag_q   <= aMag;
                        isDiv_q   <= 1'b0;
                        negHi_q   <= aNeg ^ bNeg;
                        negLo_q   <= aNeg ^ bNeg;
                        dbzPend_q <= 1'b0;
                        dbz_q     <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= MUL;
                     end
                     FUNCT_DIV, FUNCT_DIVU: begin
                        acc_q     <= {{WIDTH{1'b0}}, aMag};
                        opMag_q   <= bMag;
                        isDiv_q   <= 1'b1;
                        negHi_q   <= aNeg;
                        negLo_q   <= (aNeg ^ bNeg) & ~bZero;
                        dbzPend_q <= bZero;
                        dbz_q     <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= DIV;
                     end
                     FUNCT_MTHI: hi_q <= op_a;
                     FUNCT_MTLO: lo_q <= op_a;
                     default: ;
                  endcase
               end
            end
            MUL, DIV: begin
               if (cancel) begin
                  busy_q  <= 1'b0;
                  dbz_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  acc_q <= accStep_d;
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     cnt_q   <= '0;
                     state_q <= FIX;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            FIX: begin
               if (cancel) begin
                  dbz_q <= 1'b0;
               end else begin
                  hi_q   <= hiFix_d;
                  lo_q   <= loFix_d;
                  done_q <= 1'b1;
                  dbz_q  <= dbzPend_q;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random
// mult/div traffic compared against an arithmetic reference model.
module tb_mul_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [5:0]    funct = '0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          cancel = 1'b0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int passes = 0;
   logic [W-1:0] refHi = '0;
   logic [W-1:0] refLo = '0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .op_a(op_a), .op_b(op_b), .cancel(cancel), .busy(busy),
      .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Architectural result from plain arithmetic on the operand values.
   function automatic void refModel(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
      longint          sp;
      longint unsigned up;
      int              sa, sb;
      rz = 1'b0;
      rh = '0;
      rl = '0;
      sa = a;
      sb = b;
      if (f == FUNCT_MULT) begin
         sp = longint'(sa) * longint'(sb);
         {rh, rl} = 64'(sp);
      end else if (f == FUNCT_MULTU) begin
         up = longint'({32'b0, a}) * longint'({32'b0, b});
         {rh, rl} = 64'(up);
      end else if (b == 0) begin
         rl = '1;
         rh = a;
         rz = 1'b1;
      end else if (f == FUNCT_DIV) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            rl = a;
            rh = '0;
         end else begin
            rl = sa / sb;
            rh = sa % sb;
         end
      end else begin
         rl = a / b;
         rh = a % b;
      end
   endfunction

   task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      funct = f;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      logic         ez;
      int           cycles;
      refModel(f, a, b, eh, el, ez);
      applyStimulus(f, a, b);
      checkOutput({tag, "_done_low"}, 64'(done), 64'(0));
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(W + 1));
      checkOutput({tag, "_done"}, 64'(done), 64'(1));
      checkOutput({tag, "_hi"}, 64'(hi), 64'(eh));
      checkOutput({tag, "_lo"}, 64'(lo), 64'(el));
      checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
      refHi = eh;
      refLo = el;
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(1, 20));
         4:       return -W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0] ops [4];
      int doneCount;
      ops[0] = FUNCT_MULT;
      ops[1] = FUNCT_MULTU;
      ops[2] = FUNCT_DIV;
      ops[3] = FUNCT_DIVU;

      #2;
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_done", 64'(done), 64'(0));
      checkOutput("reset_dbz", 64'(div_by_zero), 64'(0));
      checkOutput("reset_hi", 64'(hi), 64'(0));
      checkOutput("reset_lo", 64'(lo), 64'(0));
      #20 rst_n = 1'b1;

      runOp("mult_7_m3", FUNCT_MULT, 32'd7, 32'hFFFF_FFFD);
      checkOutput("mult_7_m3_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      checkOutput("mult_7_m3_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", 64'(done), 64'(0));

      runOp("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      runOp("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
      checkOutput("div_m7_2_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      runOp("divu_min_max", FUNCT_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("divu_by_zero", FUNCT_DIVU, 32'd1234, 32'd0);
      checkOutput("divu_by_zero_hi_const", 64'(hi), 64'd1234);
      runOp("div_overflow", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("div_overflow_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
      runOp("div_neg_by_zero", FUNCT_DIV, 32'hFFFF_FF00, 32'd0);

      applyStimulus(FUNCT_MTHI, 32'hA5A5_A5A5, 32'd0);
      checkOutput("mthi_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
      checkOutput("mthi_busy", 64'(busy), 64'(0));
      refHi = 32'hA5A5_A5A5;
      applyStimulus(FUNCT_MFLO, 32'h1111_1111, 32'd0);
      checkOutput("mflo_noop_busy", 64'(busy), 64'(0));
      checkOutput("mflo_noop_lo", 64'(lo), 64'(refLo));

      applyStimulus(FUNCT_MULT, 32'd100, 32'd200);
      repeat (8) @(posedge clk);
      applyStimulus(FUNCT_MTLO, 32'h1234_5678, 32'd0);
      checkOutput("mtlo_while_busy_lo", 64'(lo), 64'(refLo));
      checkOutput("mtlo_while_busy_busy", 64'(busy), 64'(1));
      repeat (8) @(posedge clk);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      checkOutput("cancel_busy", 64'(busy), 64'(0));
      checkOutput("cancel_done", 64'(done), 64'(0));
      checkOutput("cancel_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
      checkOutput("cancel_lo", 64'(lo), 64'(refLo));
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) doneCount++;
      end
      checkOutput("cancel_no_late_done", 64'(doneCount), 64'(0));

      runOp("after_cancel", FUNCT_MULTU, 32'd3, 32'd5);

      applyStimulus(FUNCT_DIV, 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_busy", 64'(busy), 64'(0));
      checkOutput("async_reset_hi", 64'(hi), 64'(0));
      checkOutput("async_reset_lo", 64'(lo), 64'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      refHi = '0;
      refLo = '0;
      runOp("after_reset", FUNCT_DIVU, 32'd1000, 32'd7);

      for (int i = 0; i < 24; i++) begin
         runOp($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], pickOperand(), pickOperand());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
